// File: rtl/beagleg_pkg.sv
// Shared types and frame geometry for the motion-segment path.
// Defining SEGMENT_CHECKSUM_EN appends an XOR checksum byte to every frame.
package beagleg_pkg;

    localparam int SEGMENT_FIELD_BYTES   = 4;
    localparam int SEGMENT_FIELDS        = 6;
    localparam int SEGMENT_FIELD_BITS    = SEGMENT_FIELD_BYTES * 8;
    localparam int SEGMENT_PAYLOAD_BYTES = SEGMENT_FIELD_BYTES * SEGMENT_FIELDS;
    localparam int SEGMENT_PAYLOAD_BITS  = SEGMENT_PAYLOAD_BYTES * 8;

`ifdef SEGMENT_CHECKSUM_EN
    localparam int SEGMENT_FRAME_BYTES = SEGMENT_PAYLOAD_BYTES + 1;
`else
    localparam int SEGMENT_FRAME_BYTES = SEGMENT_PAYLOAD_BYTES;
`endif

    localparam int BYTE_IDX_W = $clog2(SEGMENT_FRAME_BYTES);
    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    typedef struct packed {
        logic [31:0] target_steps;
        logic [31:0] current_speed;
        logic [31:0] target_speed;
        logic [31:0] current_accel;
        logic [31:0] target_accel;
        logic [31:0] jerk;
    } motion_segment_t;

`ifdef SEGMENT_CHECKSUM_EN
    typedef enum logic [1:0] {
        LOADER_IDLE    = 2'd0,
        LOADER_COLLECT = 2'd1,
        LOADER_COMMIT  = 2'd2,
        LOADER_CHECK   = 2'd3
    } loader_state_t;
`else
    typedef enum logic [1:0] {
        LOADER_IDLE    = 2'd0,
        LOADER_COLLECT = 2'd1,
        LOADER_COMMIT  = 2'd2
    } loader_state_t;
`endif

endpackage

// File: rtl/motion_segment_holding_buffer.sv
// Single-entry holding register between the frame assembler and the consumer.
// Pops are edge-triggered on data_request; a commit may replace the entry on a pop edge.
module motion_segment_holding_buffer
    import beagleg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            commit,
    input  motion_segment_t commit_data,
    output logic            commit_done,
    input  logic            data_request,
    output logic            data_available,
    output motion_segment_t data
);

    logic            req_q_reg;
    logic            avail_reg;
    logic            avail_next;
    motion_segment_t data_reg;
    motion_segment_t data_next;
    logic            pop_event;

    // A level-high request only counts once; an edge with nothing to pop is lost.
    assign pop_event   = data_request && !req_q_reg;
    assign commit_done = commit && (!avail_reg || pop_event);

    always_comb begin
        avail_next = avail_reg;
        data_next  = data_reg;
        if (commit_done) begin
            avail_next = 1'b1;
            data_next  = commit_data;
        end else if (pop_event && avail_reg) begin
            avail_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q_reg <= 1'b0;
            avail_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            req_q_reg <= data_request;
            avail_reg <= avail_next;
            data_reg  <= data_next;
        end
    end

    assign data_available = avail_reg;
    assign data           = data_reg;

endmodule

// File: rtl/motion_segment_loader.sv
// Assembles little-endian byte frames into motion_segment_t records with abort/timeout handling.
// Optional feature macro: SEGMENT_CHECKSUM_EN (trailing XOR byte checked before commit).
module motion_segment_loader
    import beagleg_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            data_available,
    input  logic            data_request,
    output motion_segment_t data,
    output logic            frame_error,
    output logic [7:0]      error_count,
    output logic            busy
);

    localparam int GAP_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam bit TIMEOUT_EN = (BYTE_TIMEOUT != 0);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'((BYTE_TIMEOUT > 0) ? BYTE_TIMEOUT - 1 : 0);
    localparam byte_idx_t LAST_IDX = byte_idx_t'(SEGMENT_FRAME_BYTES - 1);

    loader_state_t                   state_reg;
    loader_state_t                   state_next;
    byte_idx_t                       byte_idx_reg;
    byte_idx_t                       byte_idx_next;
    logic [GAP_W-1:0]                gap_cnt_reg;
    logic [GAP_W-1:0]                gap_cnt_next;
    logic [SEGMENT_PAYLOAD_BITS-1:0] asm_reg;
    logic [SEGMENT_PAYLOAD_BITS-1:0] shifted;
    logic                            frame_error_reg;
    logic [7:0]                      error_count_reg;
    logic [7:0]                      error_count_next;

    logic            byte_accept;
    logic            load_first;
    logic            load_next;
    logic            discard;
    logic            timeout_hit;
    logic            commit_req;
    logic            commit_done;
    motion_segment_t assembled;

    logic [SEGMENT_FIELD_BITS-1:0] field_words [SEGMENT_FIELDS];

`ifdef SEGMENT_CHECKSUM_EN
    logic       capture_chk;
    logic [7:0] xor_reg;
    logic [7:0] chk_reg;
`endif

    assign byte_ready  = (state_reg == LOADER_IDLE) || (state_reg == LOADER_COLLECT);
    assign byte_accept = byte_valid && byte_ready;
    assign timeout_hit = TIMEOUT_EN && (gap_cnt_reg == GAP_LIMIT);
    assign commit_req  = (state_reg == LOADER_COMMIT);

    // New bytes enter at the top, so after a full frame byte k sits at bits [8k+7:8k].
    assign shifted = {byte_data, asm_reg[SEGMENT_PAYLOAD_BITS-1:8]};

    generate
        for (genvar gi = 0; gi < SEGMENT_FIELDS; gi++) begin : g_field
            assign field_words[gi] = asm_reg[gi*SEGMENT_FIELD_BITS +: SEGMENT_FIELD_BITS];
        end
    endgenerate

    assign assembled.target_steps  = field_words[0];
    assign assembled.current_speed = field_words[1];
    assign assembled.target_speed  = field_words[2];
    assign assembled.current_accel = field_words[3];
    assign assembled.target_accel  = field_words[4];
    assign assembled.jerk          = field_words[5];

    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        gap_cnt_next  = gap_cnt_reg;
        load_first    = 1'b0;
        load_next     = 1'b0;
        discard       = 1'b0;
`ifdef SEGMENT_CHECKSUM_EN
        capture_chk   = 1'b0;
`endif
        case (state_reg)
            LOADER_IDLE: begin
                if (byte_accept) begin
                    load_first    = 1'b1;
                    byte_idx_next = byte_idx_t'(1);
                    gap_cnt_next  = '0;
                    state_next    = LOADER_COLLECT;
                end
            end
            LOADER_COLLECT: begin
                if (frame_start) begin
                    // Restart: a byte arriving with the strobe opens the new frame.
                    discard       = 1'b1;
                    byte_idx_next = '0;
                    gap_cnt_next  = '0;
                    if (byte_accept) begin
                        load_first    = 1'b1;
                        byte_idx_next = byte_idx_t'(1);
                    end else begin
                        state_next = LOADER_IDLE;
                    end
                end else if (byte_accept) begin
                    gap_cnt_next = '0;
                    if (byte_idx_reg == LAST_IDX) begin
                        byte_idx_next = '0;
`ifdef SEGMENT_CHECKSUM_EN
                        capture_chk   = 1'b1;
                        state_next    = LOADER_CHECK;
`else
                        load_next     = 1'b1;
                        state_next    = LOADER_COMMIT;
`endif
                    end else begin
                        load_next     = 1'b1;
                        byte_idx_next = byte_idx_reg + byte_idx_t'(1);
                    end
                end else if (timeout_hit) begin
                    discard       = 1'b1;
                    byte_idx_next = '0;
                    gap_cnt_next  = '0;
                    state_next    = LOADER_IDLE;
                end else if (TIMEOUT_EN) begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
`ifdef SEGMENT_CHECKSUM_EN
            LOADER_CHECK: begin
                if (xor_reg == chk_reg) begin
                    state_next = LOADER_COMMIT;
                end else begin
                    discard    = 1'b1;
                    state_next = LOADER_IDLE;
                end
            end
`endif
            LOADER_COMMIT: begin
                if (commit_done) begin
                    state_next = LOADER_IDLE;
                end
            end
            default: begin
                state_next    = LOADER_IDLE;
                byte_idx_next = '0;
            end
        endcase
    end

    always_comb begin
        error_count_next = error_count_reg;
        if (discard && (error_count_reg != 8'hFF)) begin
            error_count_next = error_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= LOADER_IDLE;
            byte_idx_reg    <= '0;
            gap_cnt_reg     <= '0;
            asm_reg         <= '0;
            frame_error_reg <= 1'b0;
            error_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            byte_idx_reg    <= byte_idx_next;
            gap_cnt_reg     <= gap_cnt_next;
            frame_error_reg <= discard;
            error_count_reg <= error_count_next;
            if (load_first || load_next) begin
                asm_reg <= shifted;
            end
        end
    end

`ifdef SEGMENT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_reg <= '0;
            chk_reg <= '0;
        end else begin
            if (load_first) begin
                xor_reg <= byte_data;
            end else if (load_next) begin
                xor_reg <= xor_reg ^ byte_data;
            end
            if (capture_chk) begin
                chk_reg <= byte_data;
            end
        end
    end
`endif

    motion_segment_holding_buffer u_holding (
        .clk            (clk),
        .rst            (rst),
        .commit         (commit_req),
        .commit_data    (assembled),
        .commit_done    (commit_done),
        .data_request   (data_request),
        .data_available (data_available),
        .data           (data)
    );

    assign frame_error = frame_error_reg;
    assign error_count = error_count_reg;
    assign busy        = (state_reg != LOADER_IDLE) || data_available;

endmodule

// File: tb/tb_motion_segment_loader.sv
// Directed self-checking bench for motion_segment_loader (BYTE_TIMEOUT = 8).
`timescale 1ns/1ps
module tb_motion_segment_loader;
    import beagleg_pkg::*;

    localparam int TIMEOUT = 8;
`ifdef SEGMENT_CHECKSUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            data_available;
    logic            data_request;
    motion_segment_t data;
    logic            frame_error;
    logic [7:0]      error_count;
    logic            busy;

    int checks   = 0;
    int errors   = 0;
    int exp_errs = 0;
    int cyc      = 0;
    int start_cyc;

    motion_segment_t f1, f2, f3, f4, f5, f6, f7, f8, f9;

    motion_segment_loader #(.BYTE_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .data_available (data_available),
        .data_request   (data_request),
        .data           (data),
        .frame_error    (frame_error),
        .error_count    (error_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic motion_segment_t seg(input logic [31:0] a, b, c, d, e, f);
        motion_segment_t s;
        s.target_steps  = a;
        s.current_speed = b;
        s.target_speed  = c;
        s.current_accel = d;
        s.target_accel  = e;
        s.jerk          = f;
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic start);
        int waited = 0;
        while (!byte_ready && waited < 64) begin
            step();
            waited++;
        end
        if (!byte_ready) check_eq("byte_ready_wait", byte_ready, 1'b1);
        byte_valid  = 1'b1;
        byte_data   = b;
        frame_start = start;
        step();
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        frame_start = 1'b0;
    endtask

    task automatic send_bytes(input motion_segment_t s, input int first, input int count,
                              input logic start_first, input logic bad_chk);
        logic [31:0] w [6];
        logic [7:0]  x;
        logic [7:0]  b;
        w[0] = s.target_steps;
        w[1] = s.current_speed;
        w[2] = s.target_speed;
        w[3] = s.current_accel;
        w[4] = s.target_accel;
        w[5] = s.jerk;
        x = 8'h00;
        for (int i = 0; i < 24; i++) x = x ^ 8'(w[i/4] >> (8*(i%4)));
        for (int i = first; i < first + count; i++) begin
            if (i < 24) b = 8'(w[i/4] >> (8*(i%4)));
            else        b = bad_chk ? ~x : x;
            send_byte(b, start_first && (i == first));
        end
    endtask

    task automatic send_frame(input motion_segment_t s, input logic start_first, input logic bad_chk);
        send_bytes(s, 0, SEGMENT_FRAME_BYTES, start_first, bad_chk);
        $display("frame sent: steps=0x%08h jerk=0x%08h start=%0b bad_chk=%0b at cycle %0d",
                 s.target_steps, s.jerk, start_first, bad_chk, cyc);
    endtask

    task automatic pop();
        data_request = 1'b1;
        step();
        data_request = 1'b0;
        step();
        $display("pop issued at cycle %0d", cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        f1 = seg(32'h0000_0100, 32'h10, 32'h40, 32'h2, 32'h0, 32'h0);
        f2 = seg(32'h1122_3344, 32'hA5A5_0001, 32'h0000_FFFF, 32'h8000_0000, 32'h7, 32'hDEAD_BEEF);
        f3 = seg(32'hFFFF_FFF0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        f4 = seg(32'h0BAD_F00D, 32'h55, 32'hAA, 32'h1234, 32'h5678, 32'h9ABC);
        f5 = seg(32'hCAFE_0005, 32'h0101_0101, 32'h2, 32'h3, 32'hFFFF_FFFF, 32'h0);
        f6 = seg(32'h6666_6666, 32'h6, 32'h6, 32'h6, 32'h6, 32'h6);
        f7 = seg(32'h7777_0007, 32'h70, 32'h700, 32'h7000, 32'h70000, 32'h700000);
        f8 = seg(32'h8888_0008, 32'h80, 32'h800, 32'h8000, 32'h80000, 32'h800000);
        f9 = seg(32'h0000_0009, 32'h9999_9999, 32'h9, 32'h90, 32'h900, 32'h9000);

        rst = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; data_request = 1'b0;
        step(3);
        rst = 1'b0;
        step();
        check_eq("rst_avail", data_available, 1'b0);
        check_eq("rst_data", data, '0);
        check_eq("rst_ready", byte_ready, 1'b1);
        check_eq("rst_ferr", frame_error, 1'b0);
        check_eq("rst_ecnt", error_count, 8'd0);
        check_eq("rst_busy", busy, 1'b0);

        // Single frame
        send_frame(f1, 1'b0, 1'b0);
        check_eq("single_ready_low", byte_ready, 1'b0);
        check_eq("single_avail_early", data_available, 1'b0);
        check_eq("single_busy", busy, 1'b1);
        step(LAT);
        check_eq("single_avail", data_available, 1'b1);
        check_eq("single_data", data, f1);
        check_eq("single_steps", data.target_steps, 32'h100);
        check_eq("single_accel", data.current_accel, 32'h2);
        check_eq("single_ready_back", byte_ready, 1'b1);
        pop();
        check_eq("pop_avail", data_available, 1'b0);
        check_eq("pop_data_stable", data, f1);
        check_eq("pop_busy", busy, 1'b0);

        // Backpressure: second frame waits for a pop
        send_frame(f2, 1'b0, 1'b0);
        step(LAT);
        check_eq("bp_first_data", data, f2);
        send_frame(f3, 1'b0, 1'b0);
        step(LAT);
        check_eq("bp_ready_low", byte_ready, 1'b0);
        check_eq("bp_data_hold", data, f2);
        check_eq("bp_avail", data_available, 1'b1);
        data_request = 1'b1;
        step();
        check_eq("bp_data_swap", data, f3);
        check_eq("bp_avail_swap", data_available, 1'b1);
        check_eq("bp_ready_back", byte_ready, 1'b1);
        data_request = 1'b0;
        step();

        // Held request: one pop only over 50 cycles
        data_request = 1'b1;
        start_cyc = cyc;
        step();
        check_eq("held_first_pop", data_available, 1'b0);
        send_frame(f4, 1'b0, 1'b0);
        send_frame(f5, 1'b0, 1'b0);
        while (cyc - start_cyc < 50) step();
        check_eq("held_avail", data_available, 1'b1);
        check_eq("held_data", data, f4);
        check_eq("held_f5_pending", byte_ready, 1'b0);
        data_request = 1'b0;
        step();
        data_request = 1'b1;
        step();
        check_eq("held_swap", data, f5);
        data_request = 1'b0;
        step();
        pop();
        check_eq("held_drain", data_available, 1'b0);

        // Abort by frame_start after 10 bytes
        send_bytes(f6, 0, 10, 1'b0, 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        exp_errs++;
        check_eq("abort_ferr", frame_error, 1'b1);
        check_eq("abort_ecnt", error_count, 8'(exp_errs));
        step();
        check_eq("abort_pulse", frame_error, 1'b0);
        send_frame(f7, 1'b0, 1'b0);
        step(LAT);
        check_eq("abort_data", data, f7);
        check_eq("abort_ecnt_after", error_count, 8'(exp_errs));
        pop();

        // Restart with a byte on the frame_start cycle
        send_bytes(f6, 0, 5, 1'b0, 1'b0);
        send_frame(f8, 1'b1, 1'b0);
        exp_errs++;
        step(LAT);
        check_eq("restart_data", data, f8);
        check_eq("restart_ecnt", error_count, 8'(exp_errs));
        pop();

        // Inter-byte timeout after byte 5
        send_bytes(f6, 0, 6, 1'b0, 1'b0);
        step(TIMEOUT - 1);
        check_eq("to_early_ferr", frame_error, 1'b0);
        check_eq("to_early_ready", byte_ready, 1'b1);
        step();
        exp_errs++;
        check_eq("to_ferr", frame_error, 1'b1);
        check_eq("to_ecnt", error_count, 8'(exp_errs));
        send_frame(f9, 1'b0, 1'b0);
        step(LAT);
        check_eq("to_avail", data_available, 1'b1);
        check_eq("to_data", data, f9);
        pop();

`ifdef SEGMENT_CHECKSUM_EN
        send_frame(f2, 1'b0, 1'b1);
        step();
        exp_errs++;
        check_eq("chk_bad_ferr", frame_error, 1'b1);
        check_eq("chk_bad_avail", data_available, 1'b0);
        step();
        check_eq("chk_bad_ecnt", error_count, 8'(exp_errs));
        check_eq("chk_bad_avail2", data_available, 1'b0);
        send_frame(f3, 1'b0, 1'b0);
        step();
        check_eq("chk_good_wait", data_available, 1'b0);
        step();
        check_eq("chk_good_avail", data_available, 1'b1);
        check_eq("chk_good_data", data, f3);
        pop();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
